multicycle_seq: RTL and testbench

MULTICYCLE_SEQ -- requirements
Module: multicycle_seq

---
 rtl/multicycle_seq_if.sv | 38 +++
 rtl/multicycle_seq.sv | 142 ++++++++++++++
 tb/tb_multicycle_seq.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_seq_if.sv
// Control/handshake bundle between the multicycle sequencer (master) and
// the datapath, instruction memory and data memory (slave).
interface multicycle_seq_if;
    logic        start;
    logic        instr_valid;
    logic [5:0]  opcode;
    logic        equal;
    logic        alu_done;
    logic        mem_ready;

    logic        instr_req;
    logic        ir_wr;
    logic        pc_wr;
    logic        RegDst;
    logic        AluSrc;
    logic        MemtoReg;
    logic        RegWr;
    logic        MemWr;
    logic        MemRd;
    logic        nPC_sel;
    logic [2:0]  ALUctr;
    logic        alu_start;
    logic        busy;
    logic        err;
    logic [15:0] retired;

    modport master (
        input  start, instr_valid, opcode, equal, alu_done, mem_ready,
        output instr_req, ir_wr, pc_wr, RegDst, AluSrc, MemtoReg, RegWr,
               MemWr, MemRd, nPC_sel, ALUctr, alu_start, busy, err, retired
    );

    modport slave (
        output start, instr_valid, opcode, equal, alu_done, mem_ready,
        input  instr_req, ir_wr, pc_wr, RegDst, AluSrc, MemtoReg, RegWr,
               MemWr, MemRd, nPC_sel, ALUctr, alu_start, busy, err, retired
    );
endinterface

// File: rtl/multicycle_seq.sv
// Multicycle instruction sequencer: fetch/decode/execute control with bounded
// handshake waits on the multicycle ALU and the data memory.
module multicycle_seq #(
    parameter int unsigned MAX_WAIT = 32
) (
    input logic              clk,
    input logic              rst,
    multicycle_seq_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WAIT_ALU, S_MEM, S_WB, S_ERR
    } state_t;

    typedef enum logic [2:0] {
        OP_LW, OP_SW, OP_BEQ, OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_FLOAT
    } op_t;

    localparam int unsigned CW = $clog2(MAX_WAIT + 1);

    state_t        state, state_nx;
    op_t           op_q, op_nx;
    logic          taken_q, taken_nx;
    logic [CW-1:0] wait_cnt, wait_nx, wait_inc;
    logic [15:0]   retired_q, retired_nx;
    logic          is_mem, is_long;

    function automatic logic [2:0] alu_code(op_t op);
        case (op)
            OP_BEQ, OP_SUB: return 3'b001;
            OP_MUL:         return 3'b010;
            OP_DIV:         return 3'b100;
            OP_FLOAT:       return 3'b110;
            default:        return 3'b000;
        endcase
    endfunction

    assign is_mem      = (op_q == OP_LW) || (op_q == OP_SW);
    assign is_long     = (op_q == OP_MUL) || (op_q == OP_DIV) || (op_q == OP_FLOAT);
    assign wait_inc    = wait_cnt + 1'b1;
    assign bus.retired = retired_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            op_q      <= OP_LW;
            taken_q   <= 1'b0;
            wait_cnt  <= '0;
            retired_q <= '0;
        end else begin
            state     <= state_nx;
            op_q      <= op_nx;
            taken_q   <= taken_nx;
            wait_cnt  <= wait_nx;
            retired_q <= retired_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        op_nx         = op_q;
        taken_nx      = taken_q;
        wait_nx       = wait_cnt;
        retired_nx    = retired_q;
        bus.instr_req = 1'b0;
        bus.ir_wr     = 1'b0;
        bus.pc_wr     = 1'b0;
        bus.RegDst    = 1'b0;
        bus.AluSrc    = 1'b0;
        bus.MemtoReg  = 1'b0;
        bus.RegWr     = 1'b0;
        bus.MemWr     = 1'b0;
        bus.MemRd     = 1'b0;
        bus.nPC_sel   = 1'b0;
        bus.ALUctr    = '0;
        bus.alu_start = 1'b0;
        bus.err       = 1'b0;
        case (state)
            S_IDLE: if (bus.start) state_nx = S_FETCH;
            S_FETCH: begin
                bus.instr_req = 1'b1;
                if (bus.instr_valid) begin
                    bus.ir_wr = 1'b1;
                    state_nx  = S_DECODE;
                end
            end
            S_DECODE: begin
                op_nx    = op_t'(bus.opcode[2:0]);
                state_nx = (bus.opcode[5:3] != 3'b000) ? S_ERR : S_EXEC;
            end
            S_EXEC: begin
                bus.ALUctr = alu_code(op_q);
                bus.AluSrc = is_mem;
                wait_nx    = '0;
                if (is_mem) begin
                    state_nx = S_MEM;
                end else if (is_long) begin
                    bus.alu_start = 1'b1;
                    state_nx      = S_WAIT_ALU;
                end else begin
                    taken_nx = bus.equal && (op_q == OP_BEQ);
                    state_nx = S_WB;
                end
            end
            S_WAIT_ALU: begin
                bus.ALUctr = alu_code(op_q);
                wait_nx    = wait_inc;
                // A handshake on the final allowed cycle wins over the timeout.
                if (bus.alu_done)                    state_nx = S_WB;
                else if (wait_inc == CW'(MAX_WAIT))  state_nx = S_ERR;
            end
            S_MEM: begin
                bus.ALUctr = alu_code(op_q);
                bus.AluSrc = 1'b1;
                bus.MemRd  = (op_q == OP_LW);
                bus.MemWr  = (op_q == OP_SW);
                wait_nx    = wait_inc;
                if (bus.mem_ready)                   state_nx = S_WB;
                else if (wait_inc == CW'(MAX_WAIT))  state_nx = S_ERR;
            end
            S_WB: begin
                bus.pc_wr  = 1'b1;
                retired_nx = retired_q + 16'd1;
                case (op_q)
                    OP_LW: begin
                        bus.MemtoReg = 1'b1;
                        bus.RegWr    = 1'b1;
                    end
                    OP_SW:  ;
                    OP_BEQ: bus.nPC_sel = taken_q;
                    default: begin
                        bus.RegWr  = 1'b1;
                        bus.RegDst = 1'b1;
                    end
                endcase
                state_nx = bus.start ? S_FETCH : S_IDLE;
            end
            S_ERR: bus.err = 1'b1;
            default: state_nx = S_IDLE;
        endcase
        bus.busy = (state != S_IDLE) && (state != S_ERR);
    end
endmodule

// File: tb/tb_multicycle_seq.sv
// Bench for multicycle_seq: cycle-level vector table, directed corner cases and
// randomized instruction streams checked against a phase-duration model.
module tb_multicycle_seq;
    localparam int unsigned MW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multicycle_seq_if bus();

    multicycle_seq #(.MAX_WAIT(MW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic       instr_req, ir_wr, pc_wr, RegDst, AluSrc, MemtoReg, RegWr, MemWr, MemRd, nPC_sel;
        logic [2:0] ALUctr;
        logic       alu_start, busy, err;
    } outs_t;

    typedef struct packed {
        logic        rst, start, iv;
        logic [5:0]  opc;
        logic        eq;
        logic [15:0] ret;
        outs_t       exp;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int unsigned exp_retired = 0;
    vec_t        vecs[$];
    outs_t       Z, F, FV, D, EX_ADD, EX_BEQ, WB_R, WB_BT, WB_BN, ER, EX_LW, M_LW;

    function automatic outs_t sample();
        outs_t o;
        o.instr_req = bus.instr_req;  o.ir_wr    = bus.ir_wr;    o.pc_wr  = bus.pc_wr;
        o.RegDst    = bus.RegDst;     o.AluSrc   = bus.AluSrc;   o.MemtoReg = bus.MemtoReg;
        o.RegWr     = bus.RegWr;      o.MemWr    = bus.MemWr;    o.MemRd  = bus.MemRd;
        o.nPC_sel   = bus.nPC_sel;    o.ALUctr   = bus.ALUctr;   o.alu_start = bus.alu_start;
        o.busy      = bus.busy;       o.err      = bus.err;
        return o;
    endfunction

    function automatic vec_t mkv(logic r, logic s, logic iv, logic [5:0] opc, logic eq,
                                 logic [15:0] ret, outs_t e);
        vec_t v;
        v.rst = r; v.start = s; v.iv = iv; v.opc = opc; v.eq = eq; v.ret = ret; v.exp = e;
        return v;
    endfunction

    function automatic logic [2:0] ref_alu(int op);
        case (op)
            2, 4:    return 3'b001;
            5:       return 3'b010;
            6:       return 3'b100;
            7:       return 3'b110;
            default: return 3'b000;
        endcase
    endfunction

    task automatic check_outs(input string name, input outs_t exp);
        outs_t act;
        act = sample();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic noise();
        bus.instr_valid = 1'($urandom);
        bus.opcode      = 6'($urandom);
        bus.equal       = 1'($urandom);
        bus.alu_done    = 1'($urandom);
        bus.mem_ready   = 1'($urandom);
    endtask

    // Inputs are already driven; settle, compare, advance to the next falling edge.
    task automatic cyc(input string name, input outs_t e);
        #1;
        check_outs(name, e);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        noise();
        bus.start = 1'($urandom);
        @(negedge clk);
        noise();
        #1;
        check_outs("reset_outs", '0);
        check_val("reset_retired", 32'(bus.retired), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_retired = 0;
    endtask

    task automatic idle_cycle(input logic s);
        noise();
        bus.start = s;
        cyc("idle", '0);
    endtask

    // One instruction from FETCH through WB (or ERR). wd = cycles the handshake
    // stays low inside the wait phase; wd >= MW means it never arrives in time.
    task automatic run_instr(input int op, input int fd, input logic eq, input int wd,
                             input logic keep_start, output logic erred);
        outs_t e;
        logic  has_wait, is_mem;
        int    nwait;
        has_wait = (op <= 1) || (op >= 5);
        is_mem   = (op <= 1);
        erred    = 1'b0;
        for (int k = 0; k <= fd; k++) begin
            noise();
            bus.start = 1'b1;
            bus.instr_valid = (k == fd);
            e = '0; e.instr_req = 1'b1; e.ir_wr = (k == fd); e.busy = 1'b1;
            cyc("fetch", e);
        end
        noise();
        bus.start  = keep_start;
        bus.opcode = 6'(op);
        e = '0; e.busy = 1'b1;
        cyc("decode", e);
        noise();
        bus.start     = keep_start;
        bus.equal     = eq;
        bus.alu_done  = 1'b1;
        bus.mem_ready = 1'b1;
        e = '0; e.busy = 1'b1; e.ALUctr = ref_alu(op); e.AluSrc = is_mem; e.alu_start = (op >= 5);
        cyc("exec", e);
        if (has_wait) begin
            nwait = (wd >= int'(MW)) ? int'(MW) : wd + 1;
            for (int k = 0; k < nwait; k++) begin
                noise();
                bus.start = keep_start;
                if (is_mem) bus.mem_ready = (k == wd);
                else        bus.alu_done  = (k == wd);
                e = '0; e.busy = 1'b1; e.ALUctr = ref_alu(op); e.AluSrc = is_mem;
                e.MemRd = (op == 0); e.MemWr = (op == 1);
                cyc("wait", e);
            end
            if (wd >= int'(MW)) begin
                noise();
                e = '0; e.err = 1'b1;
                cyc("timeout_err", e);
                erred = 1'b1;
                return;
            end
        end
        noise();
        bus.start = keep_start;
        e = '0; e.busy = 1'b1; e.pc_wr = 1'b1;
        case (op)
            0:       begin e.MemtoReg = 1'b1; e.RegWr = 1'b1; end
            1:       ;
            2:       e.nPC_sel = eq;
            default: begin e.RegWr = 1'b1; e.RegDst = 1'b1; end
        endcase
        cyc("wb", e);
        exp_retired = (exp_retired + 1) % 65536;
        check_val("retired", 32'(bus.retired), 32'(exp_retired));
    endtask

    initial begin
        logic erred;
        logic tmo;

        Z = '0;
        F = '0;  F.instr_req = 1'b1; F.busy = 1'b1;
        FV = F;  FV.ir_wr = 1'b1;
        D = '0;  D.busy = 1'b1;
        EX_ADD = D;
        EX_BEQ = D; EX_BEQ.ALUctr = 3'b001;
        WB_R = D;  WB_R.pc_wr = 1'b1; WB_R.RegWr = 1'b1; WB_R.RegDst = 1'b1;
        WB_BN = D; WB_BN.pc_wr = 1'b1;
        WB_BT = WB_BN; WB_BT.nPC_sel = 1'b1;
        ER = '0; ER.err = 1'b1;
        EX_LW = D; EX_LW.AluSrc = 1'b1;
        M_LW = EX_LW; M_LW.MemRd = 1'b1;

        // add (fetch stalls 2 cycles), beq taken, beq not taken, illegal opcode, reset out of ERR
        vecs.push_back(mkv(0, 1, 0, 6'd0, 0, 16'd0, Z));
        vecs.push_back(mkv(0, 1, 0, 6'd0, 0, 16'd0, F));
        vecs.push_back(mkv(0, 1, 0, 6'd0, 0, 16'd0, F));
        vecs.push_back(mkv(0, 1, 1, 6'd0, 0, 16'd0, FV));
        vecs.push_back(mkv(0, 1, 0, 6'd3, 0, 16'd0, D));
        vecs.push_back(mkv(0, 1, 0, 6'd0, 0, 16'd0, EX_ADD));
        vecs.push_back(mkv(0, 1, 0, 6'd0, 0, 16'd0, WB_R));
        vecs.push_back(mkv(0, 1, 1, 6'd0, 0, 16'd1, FV));
        vecs.push_back(mkv(0, 1, 0, 6'd2, 0, 16'd1, D));
        vecs.push_back(mkv(0, 1, 0, 6'd0, 1, 16'd1, EX_BEQ));
        vecs.push_back(mkv(0, 1, 0, 6'd0, 0, 16'd1, WB_BT));
        vecs.push_back(mkv(0, 1, 1, 6'd0, 0, 16'd2, FV));
        vecs.push_back(mkv(0, 1, 0, 6'd2, 0, 16'd2, D));
        vecs.push_back(mkv(0, 1, 0, 6'd0, 0, 16'd2, EX_BEQ));
        vecs.push_back(mkv(0, 1, 0, 6'd0, 1, 16'd2, WB_BN));
        vecs.push_back(mkv(0, 1, 1, 6'd0, 0, 16'd3, FV));
        vecs.push_back(mkv(0, 1, 0, 6'b001000, 0, 16'd3, D));
        vecs.push_back(mkv(0, 1, 0, 6'd0, 0, 16'd3, ER));
        vecs.push_back(mkv(0, 1, 1, 6'd0, 0, 16'd3, ER));
        vecs.push_back(mkv(1, 1, 0, 6'd0, 0, 16'd3, ER));
        vecs.push_back(mkv(0, 0, 0, 6'd0, 0, 16'd0, Z));

        bus.start = 1'b0;
        noise();
        @(negedge clk);
        do_reset();

        foreach (vecs[i]) begin
            rst             = vecs[i].rst;
            bus.start       = vecs[i].start;
            bus.instr_valid = vecs[i].iv;
            bus.opcode      = vecs[i].opc;
            bus.equal       = vecs[i].eq;
            bus.alu_done    = 1'($urandom);
            bus.mem_ready   = 1'($urandom);
            #1;
            check_outs($sformatf("vec%0d", i), vecs[i].exp);
            check_val($sformatf("vec%0d_retired", i), 32'(bus.retired), 32'(vecs[i].ret));
            @(negedge clk);
        end

        // div: alu_done on the 5th WAIT_ALU cycle
        do_reset();
        idle_cycle(1'b1);
        run_instr(6, 2, 1'b0, 4, 1'b0, erred);
        idle_cycle(1'b0);

        // sw timeout, ERR is sticky until reset
        do_reset();
        idle_cycle(1'b1);
        run_instr(1, 0, 1'b0, int'(MW), 1'b1, erred);
        noise();
        bus.start = 1'b1;
        bus.mem_ready = 1'b1;
        cyc("err_sticky", ER);
        do_reset();

        // sw with mem_ready on the last allowed cycle; mul timeout
        idle_cycle(1'b1);
        run_instr(1, 1, 1'b0, int'(MW) - 1, 1'b0, erred);
        idle_cycle(1'b1);
        run_instr(5, 0, 1'b0, int'(MW) + 3, 1'b1, erred);
        do_reset();

        // lw with reset mid-MEM, handshake in the reset cycle is abandoned
        idle_cycle(1'b1);
        noise(); bus.start = 1'b1; bus.instr_valid = 1'b1;
        cyc("lw_fetch", FV);
        noise(); bus.opcode = 6'd0;
        cyc("lw_decode", D);
        noise();
        cyc("lw_exec", EX_LW);
        for (int k = 0; k < 3; k++) begin
            noise(); bus.mem_ready = 1'b0;
            cyc("lw_mem", M_LW);
        end
        noise(); rst = 1'b1; bus.mem_ready = 1'b1;
        cyc("lw_mem_rst", M_LW);
        noise(); rst = 1'b0; bus.start = 1'b0;
        cyc("lw_after_rst", Z);
        check_val("lw_rst_retired", 32'(bus.retired), 32'd0);

        // start dropped mid-instruction (during WAIT_ALU and before)
        idle_cycle(1'b1);
        run_instr(5, 1, 1'b0, 3, 1'b0, erred);
        idle_cycle(1'b0);
        idle_cycle(1'b1);
        run_instr(4, 0, 1'b1, 0, 1'b0, erred);
        idle_cycle(1'b0);

        // randomized instruction stream
        do_reset();
        idle_cycle(1'b1);
        for (int i = 0; i < 200; i++) begin
            int   op, fd, wd, r;
            logic eq, keep;
            op   = int'($urandom_range(0, 7));
            fd   = int'($urandom_range(0, 3));
            eq   = 1'($urandom);
            r    = int'($urandom_range(0, 19));
            wd   = (r == 0) ? int'(MW) - 1 :
                   (r == 1) ? int'(MW) + int'($urandom_range(0, 3)) : int'($urandom_range(0, 8));
            keep = ($urandom_range(0, 3) != 0);
            run_instr(op, fd, eq, wd, keep, erred);
            if (erred) begin
                do_reset();
                idle_cycle(1'b1);
            end else if (!keep) begin
                idle_cycle(1'b1);
            end
        end

        // retired wraps after 65536 back-to-back adds
        do_reset();
        bus.start = 1'b1; bus.instr_valid = 1'b1; bus.opcode = 6'd3;
        bus.equal = 1'b0; bus.alu_done = 1'b0; bus.mem_ready = 1'b0;
        tmo = 1'b0;
        for (int n = 0; n < 65536 && !tmo; n++) begin
            int t;
            t = 0;
            #1;
            while (bus.pc_wr !== 1'b1 && t < 8) begin
                @(negedge clk);
                #1;
                t++;
            end
            if (t >= 8) tmo = 1'b1;
            @(negedge clk);
            if (n == 65534) check_val("retired_ffff", 32'(bus.retired), 32'h0000_FFFF);
        end
        check_val("wrap_timeout", 32'(tmo), 32'd0);
        check_val("retired_wrap", 32'(bus.retired), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
